// File: rtl/xfm_rec_pipe.sv
// Transform-reconstruction front end: accepts one block of quantised coefficients,
// dequantises them with a QP-driven scale/shift and streams LANES coefficients per beat.
//
// state | meaning
// IDLE  | ready for a new block
// RUN   | issuing beats into the two-stage dequant pipe
// DRAIN | all beats issued, waiting for the final beat to be accepted
module xfm_rec_pipe #(
   parameter int COEFF_SIZE = 9,
   parameter int NUM_COMP   = 3,
   parameter int NUM_COEFF  = 16,
   parameter int LANES      = 4,
   parameter int OUT_WIDTH  = 16
) (
   input  logic                                   clk,
   input  logic                                   rstn,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [7:0]                             m_qp,
   input  logic [NUM_COMP-1:0]                    comp_mask,
   input  logic [NUM_COMP*NUM_COEFF*COEFF_SIZE-1:0] xfm_coeff,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [1:0]                             out_comp,
   output logic [$clog2(NUM_COEFF)-1:0]           out_idx,
   output logic [LANES*OUT_WIDTH-1:0]             out_data,
   output logic                                   out_last,
   output logic                                   done
);

   localparam int NBEATS = NUM_COEFF / LANES;
   localparam int IW     = $clog2(NUM_COEFF);
   localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int PW     = COEFF_SIZE + 7;
   localparam int VW     = PW + 8;
   localparam logic signed [VW-1:0] SAT_HI = VW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
   localparam logic signed [VW-1:0] SAT_LO = ~SAT_HI;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t state_q, state_d;
   logic   done_q, done_d;

   logic [NUM_COMP*NUM_COEFF*COEFF_SIZE-1:0] blk_q;
   logic [NUM_COMP-1:0] mask_q;
   logic [5:0]          qp_q;
   logic [1:0]          comp_q, first_comp, nxt_comp;
   logic [BW-1:0]       beat_q;
   logic                has_nxt, issue_last, advance, hs;
   logic [IW-1:0]       issue_idx;
   logic [5:0]          scale_lut;
   logic signed [PW-1:0] scale_w;
   logic [LANES*PW-1:0] prod_d;

   logic                s1_vld_q, s1_last_q;
   logic [1:0]          s1_comp_q;
   logic [IW-1:0]       s1_idx_q;
   logic [LANES*PW-1:0] s1_prod_q;

   logic                ov_q, ol_q;
   logic [1:0]          oc_q;
   logic [IW-1:0]       oi_q;
   logic [LANES*OUT_WIDTH-1:0] od_q, dq_d;

   // a stalled output beat freezes the whole pipe, including the issue counter
   assign advance = !(ov_q && !out_ready);
   assign hs      = in_valid && in_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (hs) begin
               if (comp_mask == '0) done_d = 1'b1;
               else                 state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (advance && issue_last) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (ov_q && out_ready && ol_q) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == S_IDLE);
   end

   always_comb begin
      first_comp = '0;
      for (int k = NUM_COMP - 1; k >= 0; k--)
         if (comp_mask[k]) first_comp = 2'(k);
   end

   always_comb begin
      nxt_comp = comp_q;
      has_nxt  = 1'b0;
      for (int k = NUM_COMP - 1; k >= 0; k--)
         if (mask_q[k] && (k > int'(comp_q))) begin
            nxt_comp = 2'(k);
            has_nxt  = 1'b1;
         end
   end

   assign issue_last = (beat_q == BW'(NBEATS - 1)) && !has_nxt;
   assign issue_idx  = IW'(int'(beat_q) * LANES);

   always_comb begin
      case (qp_q[2:0])
         3'd0:    scale_lut = 6'd16;
         3'd1:    scale_lut = 6'd18;
         3'd2:    scale_lut = 6'd20;
         3'd3:    scale_lut = 6'd22;
         3'd4:    scale_lut = 6'd25;
         3'd5:    scale_lut = 6'd28;
         3'd6:    scale_lut = 6'd32;
         default: scale_lut = 6'd36;
      endcase
   end
   assign scale_w = {{(PW-6){1'b0}}, scale_lut};

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [COEFF_SIZE-1:0] cf;
      logic signed [PW-1:0]  cw, prod;
      logic signed [VW-1:0]  pe, sh_v, rnd_v, v;
      assign cf   = blk_q[(int'(comp_q) * NUM_COEFF + int'(beat_q) * LANES + l) * COEFF_SIZE +: COEFF_SIZE];
      assign cw   = {{(PW-COEFF_SIZE){cf[COEFF_SIZE-1]}}, cf};
      assign prod = cw * scale_w;
      assign prod_d[l*PW +: PW] = prod;

      assign pe    = {{(VW-PW){s1_prod_q[l*PW+PW-1]}}, s1_prod_q[l*PW +: PW]};
      assign sh_v  = pe <<< qp_q[5:3];
      assign rnd_v = sh_v + VW'(8);
      assign v     = rnd_v >>> 4;
      assign dq_d[l*OUT_WIDTH +: OUT_WIDTH] = (v > SAT_HI) ? SAT_HI[OUT_WIDTH-1:0] :
                                              (v < SAT_LO) ? SAT_LO[OUT_WIDTH-1:0] :
                                                             v[OUT_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         blk_q  <= '0;
         mask_q <= '0;
         qp_q   <= '0;
         comp_q <= '0;
         beat_q <= '0;
      end else if (hs) begin
         blk_q  <= xfm_coeff;
         mask_q <= comp_mask;
         qp_q   <= (m_qp > 8'd63) ? 6'd63 : m_qp[5:0];
         comp_q <= first_comp;
         beat_q <= '0;
      end else if (state_q == S_RUN && advance) begin
         if (beat_q == BW'(NBEATS - 1)) begin
            beat_q <= '0;
            comp_q <= nxt_comp;
         end else begin
            beat_q <= beat_q + BW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_vld_q  <= 1'b0;
         s1_last_q <= 1'b0;
         s1_comp_q <= '0;
         s1_idx_q  <= '0;
         s1_prod_q <= '0;
         ov_q      <= 1'b0;
         ol_q      <= 1'b0;
         oc_q      <= '0;
         oi_q      <= '0;
         od_q      <= '0;
      end else if (advance) begin
         s1_vld_q  <= (state_q == S_RUN);
         s1_last_q <= (state_q == S_RUN) && issue_last;
         s1_comp_q <= comp_q;
         s1_idx_q  <= issue_idx;
         s1_prod_q <= prod_d;
         ov_q      <= s1_vld_q;
         ol_q      <= s1_vld_q && s1_last_q;
         oc_q      <= s1_comp_q;
         oi_q      <= s1_idx_q;
         od_q      <= dq_d;
      end
   end

   assign out_valid = ov_q;
   assign out_last  = ol_q;
   assign out_comp  = oc_q;
   assign out_idx   = oi_q;
   assign out_data  = od_q;
   assign done      = done_q;

endmodule

// File: tb/tb_xfm_rec_pipe.sv
// Directed bench for xfm_rec_pipe: hand-computed dequant values plus a small
// integer reference for full beat streams, with optional random backpressure.
module tb_xfm_rec_pipe;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [7:0]   m_qp = '0;
   logic [2:0]   comp_mask = '0;
   logic [431:0] xfm_coeff = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [1:0]   out_comp;
   logic [3:0]   out_idx;
   logic [63:0]  out_data;
   logic         out_last;
   logic         done;

   always #5 clk = ~clk;

   xfm_rec_pipe dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .m_qp      (m_qp),
      .comp_mask (comp_mask),
      .xfm_coeff (xfm_coeff),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_comp  (out_comp),
      .out_idx   (out_idx),
      .out_data  (out_data),
      .out_last  (out_last),
      .done      (done)
   );

   int          n_chk = 0;
   int          n_bad = 0;
   int          coef [3][16];
   logic [63:0] first_data;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int ref_dq(input int c, input int qp);
      int scale_tab [8] = '{16, 18, 20, 22, 25, 28, 32, 36};
      int qc, v;
      qc = (qp > 63) ? 63 : qp;
      v  = c * scale_tab[qc % 8] * (1 << (qc / 8)) + 8;
      v  = v >>> 4;
      if (v > 32767)  v = 32767;
      if (v < -32768) v = -32768;
      return v;
   endfunction

   function automatic logic [63:0] ref_beat(input int k, input int b, input int qp);
      logic [63:0] r;
      for (int l = 0; l < 4; l++) r[l*16 +: 16] = 16'(ref_dq(coef[k][b*4+l], qp));
      return r;
   endfunction

   function automatic logic [431:0] pack_blk();
      logic [431:0] p;
      for (int k = 0; k < 3; k++)
         for (int j = 0; j < 16; j++) p[(k*16+j)*9 +: 9] = 9'(coef[k][j]);
      return p;
   endfunction

   task automatic fill(input int v0, input int v1, input int v2);
      for (int j = 0; j < 16; j++) begin
         coef[0][j] = v0;
         coef[1][j] = v1;
         coef[2][j] = v2;
      end
   endtask

   task automatic fill_varied();
      for (int k = 0; k < 3; k++)
         for (int j = 0; j < 16; j++) coef[k][j] = (k*37 + j*13) % 200 - 100;
   endtask

   // abort_n > 0: pull reset right after that many beats have been accepted
   task automatic run_block(input int qp, input logic [2:0] mask, input bit bp, input int abort_n);
      logic [63:0] e_data [12];
      int          e_comp [12];
      int          e_idx  [12];
      int          total, nb, last_c;
      bit          got_first, fin;
      logic        rdy;
      total = 0;
      for (int k = 0; k < 3; k++)
         if (mask[k])
            for (int b = 0; b < 4; b++) begin
               e_data[total] = ref_beat(k, b, qp);
               e_comp[total] = k;
               e_idx[total]  = b * 4;
               total++;
            end
      @(negedge clk);
      in_valid  = 1'b1;
      m_qp      = 8'(qp);
      comp_mask = mask;
      xfm_coeff = pack_blk();
      chk("in_ready_idle", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      nb = 0; last_c = 0; got_first = 1'b0; fin = 1'b0;
      for (int c = 1; c <= 300 && !fin; c++) begin
         @(negedge clk);
         if (done) begin
            chk("beat_count", 64'(nb), 64'(total));
            chk("done_cycle", 64'(c), 64'(last_c + 1));
            chk("in_ready_done", 64'(in_ready), 64'd1);
            fin = 1'b1;
         end else begin
            if (c == 2 && mask != 3'b000) chk("in_ready_busy", 64'(in_ready), 64'd0);
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            if (out_valid) begin
               if (!got_first) begin
                  chk("first_latency", 64'(c), 64'd3);
                  first_data = out_data;
                  got_first  = 1'b1;
               end
               if (nb >= total) begin
                  chk("extra_beat", 64'(out_valid), 64'd0);
               end else begin
                  chk("beat_data", out_data, e_data[nb]);
                  chk("beat_comp", 64'(out_comp), 64'(e_comp[nb]));
                  chk("beat_idx", 64'(out_idx), 64'(e_idx[nb]));
                  chk("beat_last", 64'(out_last), 64'(nb == total - 1));
                  if (rdy) begin
                     nb++;
                     last_c = c;
                     if (nb == abort_n) begin
                        @(posedge clk);
                        #2 rstn = 1'b0;
                        #1;
                        chk("rst_out_valid", 64'(out_valid), 64'd0);
                        chk("rst_in_ready", 64'(in_ready), 64'd1);
                        chk("rst_out_data", out_data, 64'd0);
                        @(negedge clk);
                        rstn = 1'b1;
                        fin  = 1'b1;
                     end
                  end
               end
            end
         end
      end
      if (!fin) chk("timeout_done", 64'(done), 64'd1);
      out_ready = 1'b1;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_out_last", 64'(out_last), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_out_data", out_data, 64'd0);
      chk("reset_out_idx", 64'(out_idx), 64'd0);
      chk("reset_out_comp", 64'(out_comp), 64'd0);
      rstn = 1'b1;

      fill(7, 7, 7);
      run_block(0, 3'b111, 1'b0, -1);
      chk("unity_lane0", 64'(first_data[15:0]), 64'(16'd7));
      chk("unity_lane3", 64'(first_data[63:48]), 64'(16'd7));

      fill(5, 0, 0);
      run_block(8, 3'b001, 1'b0, -1);
      chk("qp8_c5", 64'(first_data[15:0]), 64'(16'd10));

      fill(-3, 0, 0);
      run_block(13, 3'b001, 1'b0, -1);
      chk("qp13_cm3", 64'(first_data[15:0]), 64'(16'hFFF6));

      fill(1, 0, 0);
      run_block(70, 3'b001, 1'b0, -1);
      chk("qp70_as_63", 64'(first_data[15:0]), 64'(16'd288));

      fill(255, -256, 0);
      run_block(63, 3'b011, 1'b0, -1);
      chk("sat_pos", 64'(first_data[15:0]), 64'(16'h7FFF));

      fill(-256, 0, 0);
      run_block(63, 3'b001, 1'b0, -1);
      chk("sat_neg", 64'(first_data[15:0]), 64'(16'h8000));

      fill_varied();
      run_block(5, 3'b010, 1'b0, -1);

      run_block(0, 3'b000, 1'b0, -1);

      run_block(21, 3'b111, 1'b1, -1);
      run_block(44, 3'b101, 1'b1, -1);

      run_block(3, 3'b111, 1'b0, 5);
      fill(7, 7, 7);
      run_block(0, 3'b111, 1'b0, -1);
      chk("post_rst_lane0", 64'(first_data[15:0]), 64'(16'd7));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/xfm_rec_pipe.md
# xfm_rec_pipe

Parametrised, pipelined successor to the transform-reconstruction front end. It accepts one transform block per handshake: NUM_COMP components × NUM_COEFF quantised coefficients. It dequantises the coefficients with a QP-driven scale/shift and streams them out LANES at a time, component by component. It sits between the entropy decoder's coefficient unpack and the inverse transform. It adds backpressure, per-component skipping and output saturation.

## Interface
Parameters:
- COEFF_SIZE, 9, signed input coefficient width
- NUM_COMP, 3, components per block
- NUM_COEFF, 16, coefficients per component; must be a multiple of LANES
- LANES, 4, coefficients emitted per output beat
- OUT_WIDTH, 16, signed dequantised output width

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- in_valid  in  1  block available
- in_ready  out  1  block accepted when in_valid && in_ready
- m_qp  in  8  quantisation parameter; sampled with the block
- comp_mask  in  NUM_COMP  bit k=1 processes component k; sampled with the block
- xfm_coeff  in  NUM_COMP*NUM_COEFF*COEFF_SIZE  coefficient j of component k at bits [(k*NUM_COEFF+j)*COEFF_SIZE +: COEFF_SIZE]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_comp  out  2  component index of the beat
- out_idx  out  $clog2(NUM_COEFF)  index of lane 0 coefficient
- out_data  out  LANES*OUT_WIDTH  lane l holds coefficient out_idx+l, at bits [l*OUT_WIDTH +: OUT_WIDTH]
- out_last  out  1  last beat of the block
- done  out  1  one-cycle pulse when the block completes

## Operation
- Reset values: in_ready=1, out_valid=0, out_last=0, done=0, out_comp=0, out_idx=0, out_data=0. The FSM resets to IDLE.
- FSM states:
  - IDLE: in_ready=1. On handshake, register the block, mask and qp_c = min(m_qp,63), then go to RUN. If comp_mask==0, go to IDLE instead and pulse done next cycle; no beats are emitted.
  - RUN: in_ready=0. The issue counter walks the unmasked components in ascending k, NUM_COEFF/LANES beats each, out_idx stepping 0, LANES, 2*LANES, .... After the last beat is issued into the pipe, go to DRAIN.
  - DRAIN: wait until the final beat handshakes (out_valid && out_ready && out_last). Then pulse done and return to IDLE.
- Dequantisation per coefficient c:
  - scale = {16,18,20,22,25,28,32,36}[qp_c[2:0]]
  - shift = qp_c[5:3]
  - v = ((c*scale) <<< shift + 8) >>> 4, computed in signed arithmetic at least COEFF_SIZE+6+7 bits wide
  - Result is v saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Pipeline:
  - Stage 1 registers the LANES products plus tags (comp, idx, last).
  - Stage 2 registers the shift, round and clip into the out_* registers.
- Stall: when out_valid && !out_ready, the issue counter, stage 1 and stage 2 all hold and out_* stay stable. No beat is dropped or duplicated.
- out_last is 1 only on the final beat of the last unmasked component.
- A new block cannot be accepted before done (in_ready=0 throughout RUN and DRAIN).

## Timing
- Handshake in cycle N: the first beat is out_valid at cycle N+3 (registered capture at N+1, stage 1 at N+2, stage 2 at N+3).
- With out_ready held at 1, beats are back-to-back: one per cycle, popcount(comp_mask)*NUM_COEFF/LANES beats total.
- done pulses the cycle after the out_last handshake. in_ready returns to 1 in that same cycle.
- All-masked block: done pulses at N+1, with in_ready=1 at N+1.
- Reset asserted mid-block: everything returns to reset values asynchronously and the partial block is discarded.
- out_ready low while out_valid=0: no effect; the pipe keeps filling until stage 2 holds a beat.

## Test plan
- Unity gain: qp=0, mask=3'b111, all coefficients = 7 → 12 beats, every lane = 7, out_comp order 0,0,0,0,1,...,2, out_idx 0,4,8,12, out_last on beat 12 only, done one cycle later.
- Scaling and rounding: qp=8, coefficient 5 → 10; qp=13, coefficient -3 → -10; qp=70 behaves exactly as qp=63.
- Saturation: qp=63, coefficient 255 → 32767; coefficient -256 → -32768.
- Masking: mask=3'b010 → 4 beats, all out_comp=1, out_last on the 4th. mask=0 → no out_valid, done at N+1.
- Backpressure: toggle out_ready pseudo-randomly on a 3-component block → out_data stable while stalled; the 12 beats match the reference model in order with no loss or duplication.
- Reset mid-RUN: assert rstn=0 after the 5th beat → out_valid=0 and in_ready=1 immediately; the next block processes correctly from beat 0.
